zone_irrigation_scheduler: RTL

Parametrised multi-zone successor to the single-zone irrigation path. It validates the three water-level sensors and runs a hysteretic water-supply refill valve. It scans ZONES earth-humidity inputs round-robin and irrigates each dry zone for a programmable number of ticks, using either the sprinkler bomb or the dripper valve. It sits between the sensor inputs and the LED/7-segment/matrix display logic, which consume its status outputs.

---
 rtl/zone_irrigation_scheduler_if.sv | 43 ++++
 rtl/zone_irrigation_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/zone_irrigation_scheduler_if.sv
// Sensor, configuration and status bundle of the multi-zone irrigation scheduler.
// The tick strobe is a plain one-cycle enable and is not a valid/ready handshake.
interface zone_irrigation_scheduler_if #(
  parameter int ZONES     = 4,
  parameter int DUR_WIDTH = 6
);
  localparam int ZW = $clog2(ZONES);

  logic                 tick;
  logic                 enable;
  logic                 low_water_level;
  logic                 mid_water_level;
  logic                 high_water_level;
  logic [ZONES-1:0]     earth_humidity;
  logic                 air_humidity;
  logic                 low_temperature;
  logic [DUR_WIDTH-1:0] duration;

  logic [ZONES-1:0]     zone_valvule;
  logic                 splinker_bomb;
  logic                 dripper_valvule;
  logic                 water_supply_valvule;
  logic                 alarm;
  logic                 conflicting_values;
  logic [ZW-1:0]        active_zone;
  logic [DUR_WIDTH-1:0] remaining;
  logic                 busy;
  logic [1:0]           fsm_state;

  modport master (
    output tick, enable, low_water_level, mid_water_level, high_water_level,
           earth_humidity, air_humidity, low_temperature, duration,
    input  zone_valvule, splinker_bomb, dripper_valvule, water_supply_valvule,
           alarm, conflicting_values, active_zone, remaining, busy, fsm_state
  );

  modport slave (
    input  tick, enable, low_water_level, mid_water_level, high_water_level,
           earth_humidity, air_humidity, low_temperature, duration,
    output zone_valvule, splinker_bomb, dripper_valvule, water_supply_valvule,
           alarm, conflicting_values, active_zone, remaining, busy, fsm_state
  );
endinterface

// File: rtl/zone_irrigation_scheduler.sv
// Round-robin multi-zone irrigation scheduler with water-level validation and
// a hysteretic refill valve. All outputs come straight from registers.
module zone_irrigation_scheduler #(
  parameter int ZONES     = 4,
  parameter int DUR_WIDTH = 6
) (
  input logic                  clock,
  input logic                  reset,
  zone_irrigation_scheduler_if.slave bus
);
  localparam int ZW = $clog2(ZONES);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SCAN     = 2'd1;
  localparam logic [1:0] IRRIGATE = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  logic [1:0]           state, state_n;
  logic [ZW-1:0]        zone, zone_n, zone_inc;
  logic [DUR_WIDTH-1:0] remaining, remaining_n;
  logic                 mode_spr, mode_spr_n;
  logic                 conflict, water_ok, zone_humid;
  logic                 conflict_q, alarm_q, supply_q;
  logic [ZONES-1:0]     valves_q;
  logic                 spr_q, drip_q, busy_q;

  assign conflict   = (bus.high_water_level & ~bus.mid_water_level) |
                      (bus.mid_water_level & ~bus.low_water_level);
  assign water_ok   = bus.low_water_level & ~conflict;
  assign zone_humid = bus.earth_humidity[zone];
  assign zone_inc   = (zone == ZW'(ZONES - 1)) ? '0 : zone + ZW'(1);

  // Priority: enable low, then water loss, then zone end, then tick decrement.
  always_comb begin
    state_n     = state;
    zone_n      = zone;
    remaining_n = remaining;
    mode_spr_n  = mode_spr;
    if (!bus.enable) begin
      state_n     = IDLE;
      remaining_n = '0;
    end else begin
      case (state)
        IDLE: state_n = SCAN;
        SCAN: begin
          if (!zone_humid && bus.duration != '0 && water_ok) begin
            state_n     = IRRIGATE;
            remaining_n = bus.duration;
            mode_spr_n  = ~bus.air_humidity & ~bus.low_temperature & bus.mid_water_level;
          end else begin
            zone_n = zone_inc;
          end
        end
        IRRIGATE: begin
          if (!water_ok) begin
            state_n = HOLD;
          end else if (zone_humid || (bus.tick && remaining == DUR_WIDTH'(1))) begin
            state_n     = SCAN;
            remaining_n = '0;
            zone_n      = zone_inc;
          end else if (bus.tick) begin
            remaining_n = remaining - DUR_WIDTH'(1);
          end
        end
        HOLD: begin
          if (zone_humid) begin
            state_n     = SCAN;
            remaining_n = '0;
            zone_n      = zone_inc;
          end else if (water_ok) begin
            state_n = IRRIGATE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      zone       <= '0;
      remaining  <= '0;
      mode_spr   <= 1'b0;
      conflict_q <= 1'b0;
      alarm_q    <= 1'b0;
      supply_q   <= 1'b0;
      valves_q   <= '0;
      spr_q      <= 1'b0;
      drip_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      zone       <= zone_n;
      remaining  <= remaining_n;
      mode_spr   <= mode_spr_n;
      conflict_q <= conflict;
      alarm_q    <= conflict | ~bus.mid_water_level;
      // Refill hysteresis: open below mid, close at high; hold in between.
      if (~bus.mid_water_level & ~conflict)
        supply_q <= 1'b1;
      else if (bus.high_water_level | conflict)
        supply_q <= 1'b0;
      valves_q <= (state_n == IRRIGATE) ? (ZONES'(1) << zone_n) : '0;
      spr_q    <= (state_n == IRRIGATE) &&  mode_spr_n;
      drip_q   <= (state_n == IRRIGATE) && !mode_spr_n;
      busy_q   <= (state_n == IRRIGATE) || (state_n == HOLD);
    end
  end

  assign bus.zone_valvule         = valves_q;
  assign bus.splinker_bomb        = spr_q;
  assign bus.dripper_valvule      = drip_q;
  assign bus.water_supply_valvule = supply_q;
  assign bus.alarm                = alarm_q;
  assign bus.conflicting_values   = conflict_q;
  assign bus.active_zone          = zone;
  assign bus.remaining            = remaining;
  assign bus.busy                 = busy_q;
  assign bus.fsm_state            = state;
endmodule
